// File: rtl/riscv_v_pkg.sv
// Shared constants for the vector CSR unit.
//   CSR_*      : bit index of each CSR inside the 6-bit per-source enable vector
//   *_W        : architectural field widths
//   VTYPE_RST  : vtype reset value (vill set, everything else clear)
package riscv_v_pkg;

  localparam int NUM_CSR      = 6;

  localparam int CSR_VSSTATUS = 0;
  localparam int CSR_VTYPE    = 1;
  localparam int CSR_VL       = 2;
  localparam int CSR_VSTART   = 3;
  localparam int CSR_VXRM     = 4;
  localparam int CSR_VXSAT    = 5;

  localparam int VSSTATUS_W   = 11;
  localparam int VTYPE_W      = 9;
  localparam int VXRM_W       = 2;
  localparam int VXSAT_W      = 1;

  localparam logic [VTYPE_W-1:0] VTYPE_RST = 9'h100;

endpackage

// File: rtl/riscv_v_en_pipe.sv
// Write-enable delay line from ID to EXE.
//   clk, rst (async, active-low), stall (hold all stages), flush (clear all stages)
//   en_in  : enables entering at ID
//   en_out : enables at the last stage (EXE)
//   en_any : OR of every stage, EXE included
module riscv_v_en_pipe #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic [WIDTH-1:0] en_in,
  output logic [WIDTH-1:0] en_out,
  output logic [WIDTH-1:0] en_any
);

  logic [WIDTH-1:0] stg [DEPTH];

  // flush wins over stall so a held pipeline can still be killed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) stg[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) stg[i] <= '0;
    end else if (!stall) begin
      stg[0] <= en_in;
      for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
    end
  end

  assign en_out = stg[DEPTH-1];

  always_comb begin
    en_any = '0;
    for (int i = 0; i < DEPTH; i++) en_any = en_any | stg[i];
  end

endmodule

// File: rtl/riscv_v_csr_unit.sv
// Vector CSR unit: collects per-source CSR writes at ID, carries the enables
// LATENCY stages to EXE, picks one winner per CSR and commits it.
//   clk, rst (async, active-low), stall, flush
//   src_wr_en_id  [NUM_SRC*6]  : per-source enables, {vxsat,vxrm,vstart,vl,vtype,vsstatus}
//   src_data_exe  [NUM_SRC*32] : per-source data at EXE
//   vsstatus, vtype, vl, vstart, vxrm, vxsat, vcsr, vlenb : architectural values
//   csr_busy_id     : write in flight per CSR
//   wr_conflict_exe : two or more sources hit the same CSR at EXE
//   csr_wr_en_exe, csr_wr_data_exe : trace of what is committing
module riscv_v_csr_unit
  import riscv_v_pkg::*;
#(
  parameter int NUM_SRC      = 2,
  parameter int LATENCY      = 1,
  parameter int VLEN         = 128,
  parameter int VXSAT_STICKY = 1,
  localparam int VL_W        = $clog2(VLEN) + 1,
  localparam int VST_W       = $clog2(VLEN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    flush,
  input  logic [NUM_SRC*6-1:0]    src_wr_en_id,
  input  logic [NUM_SRC*32-1:0]   src_data_exe,
  output logic [VSSTATUS_W-1:0]   vsstatus,
  output logic [VTYPE_W-1:0]      vtype,
  output logic [VL_W-1:0]         vl,
  output logic [VST_W-1:0]        vstart,
  output logic [VXRM_W-1:0]       vxrm,
  output logic [VXSAT_W-1:0]      vxsat,
  output logic [2:0]              vcsr,
  output logic [VL_W-1:0]         vlenb,
  output logic [5:0]              csr_busy_id,
  output logic                    wr_conflict_exe,
  output logic [5:0]              csr_wr_en_exe,
  output logic [31:0]             csr_wr_data_exe
);

  localparam logic [VL_W-1:0] VLMAX = VL_W'(VLEN);

  logic [NUM_SRC*NUM_CSR-1:0] en_exe;
  logic [NUM_SRC*NUM_CSR-1:0] en_any;
  logic [31:0]                csr_data [NUM_CSR];
  logic [NUM_CSR-1:0]         commit;
  logic [VL_W-1:0]            vl_wr;

  riscv_v_en_pipe #(
    .WIDTH (NUM_SRC*NUM_CSR),
    .DEPTH (LATENCY)
  ) u_en_pipe (
    .clk    (clk),
    .rst    (rst),
    .stall  (stall),
    .flush  (flush),
    .en_in  (src_wr_en_id),
    .en_out (en_exe),
    .en_any (en_any)
  );

  always_comb begin
    csr_busy_id = '0;
    for (int s = 0; s < NUM_SRC; s++)
      csr_busy_id = csr_busy_id | en_any[s*NUM_CSR +: NUM_CSR];
  end

  // per CSR: lowest-index enabled source wins, any further hit is a conflict
  always_comb begin
    csr_wr_en_exe   = '0;
    wr_conflict_exe = 1'b0;
    for (int c = 0; c < NUM_CSR; c++) begin
      csr_data[c] = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
        if (en_exe[s*NUM_CSR + c]) begin
          if (csr_wr_en_exe[c]) wr_conflict_exe = 1'b1;
          else                  csr_data[c] = src_data_exe[s*32 +: 32];
          csr_wr_en_exe[c] = 1'b1;
        end
      end
    end
  end

  // trace data: walk from lowest priority up so the highest-priority source lands last
  always_comb begin
    csr_wr_data_exe = '0;
    for (int s = NUM_SRC-1; s >= 0; s--)
      if (|en_exe[s*NUM_CSR +: NUM_CSR]) csr_wr_data_exe = src_data_exe[s*32 +: 32];
  end

  assign commit = csr_wr_en_exe & {NUM_CSR{~stall}};
  assign vl_wr  = (csr_data[CSR_VL] > 32'(VLEN)) ? VLMAX : csr_data[CSR_VL][VL_W-1:0];

  // commit does not look at flush: a write already at EXE still lands
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsstatus <= '0;
      vtype    <= VTYPE_RST;
      vl       <= '0;
      vstart   <= '0;
      vxrm     <= '0;
      vxsat    <= '0;
    end else begin
      if (commit[CSR_VSSTATUS]) vsstatus <= csr_data[CSR_VSSTATUS][VSSTATUS_W-1:0];
      if (commit[CSR_VTYPE])    vtype    <= csr_data[CSR_VTYPE][VTYPE_W-1:0];
      if (commit[CSR_VL])       vl       <= vl_wr;
      if (commit[CSR_VSTART])   vstart   <= csr_data[CSR_VSTART][VST_W-1:0];
      if (commit[CSR_VXRM])     vxrm     <= csr_data[CSR_VXRM][VXRM_W-1:0];
      if (commit[CSR_VXSAT])
        vxsat <= (VXSAT_STICKY != 0) ? (vxsat | csr_data[CSR_VXSAT][0])
                                     : csr_data[CSR_VXSAT][0];
    end
  end

  assign vcsr  = {vxrm, vxsat};
  assign vlenb = VL_W'(VLEN / 8);

  logic unused_data_bits;
  assign unused_data_bits = ^{csr_data[CSR_VSSTATUS][31:VSSTATUS_W],
                              csr_data[CSR_VTYPE][31:VTYPE_W],
                              csr_data[CSR_VSTART][31:VST_W],
                              csr_data[CSR_VXRM][31:VXRM_W],
                              csr_data[CSR_VXSAT][31:1]};

endmodule

// File: doc/riscv_v_csr_unit.md
RISCV_V_CSR_UNIT -- requirements
Module: riscv_v_csr_unit

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2: number of CSR write sources; index 0 is highest priority.
REQ-002 SHALL have parameter LATENCY, default 1: ID-to-EXE stages; legal range 1..4.
REQ-003 SHALL have parameter VLEN, default 128: vector register width in bits.
REQ-004 SHALL have parameter VXSAT_STICKY, default 1: when 1, vxsat writes OR into the current value.
REQ-005 SHALL have port clk, input, 1: the single clock; all state is rising-edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port stall, input, 1: holds the pipeline and blocks commit.
REQ-008 SHALL have port flush, input, 1: synchronously clears in-flight write enables.
REQ-009 SHALL have port src_wr_en_id, input, NUM_SRC*6: per-source CSR write requests at ID; CSR order is {vxsat, vxrm, vstart, vl, vtype, vsstatus} (bit 0 is vsstatus).
REQ-010 SHALL have port src_data_exe, input, NUM_SRC*32: per-source write data at EXE, LSB-aligned.
REQ-011 SHALL have outputs vsstatus (11), vtype (9), vl (VL_W), vstart (VST_W), vxrm (2), vxsat (1): the architectural values.
REQ-012 SHALL have output vcsr, 3: {vxrm, vxsat}.
REQ-013 SHALL have output vlenb, VL_W: constant VLEN/8.
REQ-014 SHALL have output csr_busy_id, 6: per-CSR flag, set while any write to that CSR is in flight.
REQ-015 SHALL have output wr_conflict_exe, 1: more than one source writes the same CSR at EXE.
REQ-016 SHALL have outputs csr_wr_en_exe (6) and csr_wr_data_exe (32): the committing enables and the merged data, for trace.

Function
REQ-017 SHALL define VL_W = $clog2(VLEN)+1 and VST_W = $clog2(VLEN), so that vl can hold VLMAX = VLEN.
REQ-018 SHALL delay src_wr_en_id by exactly LATENCY stages to EXE; each stage advances only when stall=0.
REQ-019 SHALL clear every stage's enables on flush=1 at the next edge; flush takes precedence over stall.
REQ-020 SHALL select, per CSR, the lowest-index source whose EXE enable is set; the written value is that source's src_data_exe slice.
REQ-021 SHALL assert wr_conflict_exe combinationally when, for any CSR, two or more sources are enabled at EXE; the winner still commits.
REQ-022 SHALL commit the selected value to the CSR register at the clock edge where the EXE enable is set and stall=0; under stall, no commit occurs and the enable is held.
REQ-023 SHALL saturate a vl write greater than VLEN to VLEN.
REQ-024 SHALL truncate a vstart write to its low VST_W bits.
REQ-025 SHALL, when VXSAT_STICKY=1, write vxsat as old|data[0]; otherwise write data[0].
REQ-026 SHALL derive csr_busy_id[c] as the OR of bit c across all pipeline stages, including EXE; it clears the cycle after commit or flush.
REQ-027 SHALL drive csr_wr_en_exe[c] as the OR across sources at EXE, and csr_wr_data_exe as the data of the highest-priority source enabled on any CSR (0 if none).
REQ-028 SHALL make register outputs reflect a committed write one cycle after the commit edge; there is no bypass.
REQ-029 SHALL give a commit priority over a simultaneous flush for the write already at EXE when stall=0.

Reset
REQ-030 SHALL, on rst=0 and independent of clk, set vtype=9'h100 (vill set), vl=0, vstart=0, vxrm=0, vxsat=0, vsstatus=0.
REQ-031 SHALL clear all pipeline enables on reset, so csr_busy_id=0, wr_conflict_exe=0 and csr_wr_en_exe=0.
REQ-032 SHALL discard any write in flight when reset asserts mid-operation; no partial commit occurs after release.

Structure
REQ-033 SHALL place the CSR index constants, the field widths (VSSTATUS 11, VTYPE 9, VXRM 2, VXSAT 1) and the vtype reset value in riscv_v_pkg.
REQ-034 SHALL implement the per-stage enable pipeline as one sub-module, riscv_v_en_pipe, parametrised by width and depth, with stall and flush.

Verification
REQ-035 SHALL verify: reset release -> vtype=0x100, vl=0, vlenb=16 (VLEN=128), busy=0.
REQ-036 SHALL verify: src0 writes vl at ID, data 200, LATENCY=2 -> busy[vl] high for 2 cycles, then vl=128 (saturated).
REQ-037 SHALL verify: src0 and src1 write vxrm at the same cycle, data 1 and 3 -> wr_conflict_exe=1, then vxrm=1.
REQ-038 SHALL verify: vxsat=1, then src1 writes 0 with VXSAT_STICKY=1 -> vxsat stays 1; with VXSAT_STICKY=0 -> vxsat=0.
REQ-039 SHALL verify: stall held for 3 cycles while a vtype write sits at EXE -> no commit during the stall; a single commit of 0x003 follows release.
REQ-040 SHALL verify: flush while a vstart write is in the ID stage -> vstart is unchanged and busy clears next cycle; async reset mid-flight -> all registers take their reset values.
